// File: rtl/arcade_input_pkg.sv
// ============================================================================
// Module   : arcade_input_pkg
// Brief    : Shared types and constants for the arcade configuration/input block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arcade_input_pkg;

  typedef enum logic [7:0] {
    MOD_BWIDOW   = 8'd0,
    MOD_GRAVITAR = 8'd1,
    MOD_LUNARBAT = 8'd2,
    MOD_SPACDUEL = 8'd3
  } mod_e;

  typedef enum logic [1:0] {
    CS_IDLE     = 2'd0,
    CS_HOLD     = 2'd1,
    CS_WAIT_REL = 2'd2
  } coin_state_e;

  // Bit positions inside the MiSTer joystick word
  localparam int JOY_RIGHT      = 0;
  localparam int JOY_LEFT       = 1;
  localparam int JOY_DOWN       = 2;
  localparam int JOY_UP         = 3;
  localparam int JOY_FIRE_RIGHT = 4;
  localparam int JOY_FIRE_LEFT  = 5;
  localparam int JOY_FIRE_UP    = 6;
  localparam int JOY_FIRE_DOWN  = 7;
  localparam int JOY_START1     = 8;
  localparam int JOY_START2     = 9;
  localparam int JOY_COIN       = 10;

  localparam int PORT_SYS = 0;
  localparam int PORT_SW0 = 1;
  localparam int PORT_SW1 = 2;
  localparam int PORT_JOY = 3;
  localparam int PORT_BTN = 4;

  localparam logic [7:0] PORT_IDLE = 8'hff;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire_up;
    logic fire_down;
    logic fire_left;
    logic fire_right;
    logic start1;
    logic start2;
    logic coin;
  } pad_t;

endpackage

`default_nettype wire

// File: rtl/arcade_input_cfg_coin_stretch.sv
// ============================================================================
// Module   : coin_stretch
// Brief    : Stretches a coin press to at least HOLD cycles, longer if held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_stretch
  import arcade_input_pkg::*;
#(
  parameter int HOLD = 240000
) (
  input  logic clk_12,
  input  logic reset,
  input  logic coin,
  output logic coin_s
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  if (HOLD < 1) begin : g_bad_hold
    $error("coin_stretch: HOLD must be at least 1");
  end

  coin_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          coin_prev_q, coin_prev_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coin_prev_d = coin;
    case (state_q)
      CS_IDLE: begin
        if (coin && !coin_prev_q) begin
          state_d = CS_HOLD;
          cnt_d   = CW'(HOLD - 1);
        end
      end
      CS_HOLD: begin
        // Fresh rising edges here are deliberately ignored
        if (cnt_q == '0) begin
          state_d = coin ? CS_WAIT_REL : CS_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CS_WAIT_REL: begin
        if (!coin) state_d = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q     <= CS_IDLE;
      cnt_q       <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_prev_q <= coin_prev_d;
    end
  end

  assign coin_s = (state_q != CS_IDLE);

endmodule

`default_nettype wire

// File: rtl/arcade_input_cfg.sv
// ============================================================================
// Module   : arcade_input_cfg
// Brief    : DIP/game-select capture from the HPS stream and joystick-to-port
//            mapping for the vector arcade cores. ARCADE_CLK3K_EN enables clk3k.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arcade_input_cfg
  import arcade_input_pkg::*;
#(
  parameter int NUM_DIP_BYTES = 8,
  parameter int NUM_PORTS     = 5,
  parameter int NUM_MODS      = 4,
  parameter int DIP_INDEX     = 254,
  parameter int MOD_INDEX     = 1,
  parameter int COIN_HOLD     = 240000,
  parameter int CLK3K_HALF    = 2000
) (
  input  logic                       clk_12,
  input  logic                       reset,
  input  logic                       ioctl_download,
  input  logic                       ioctl_wr,
  input  logic [24:0]                ioctl_addr,
  input  logic [7:0]                 ioctl_dout,
  input  logic [7:0]                 ioctl_index,
  input  logic [15:0]                joy_0,
  input  logic [15:0]                joy_1,
  output logic [NUM_DIP_BYTES*8-1:0] sw_out,
  output logic [NUM_MODS-1:0]        mod_onehot,
  output logic                       cfg_valid,
  output logic [NUM_PORTS*8-1:0]     input_flat,
  output logic                       clk3k
);

  localparam int AW = $clog2(NUM_DIP_BYTES);

  if (NUM_DIP_BYTES < 2 || NUM_DIP_BYTES > 32 ||
      (NUM_DIP_BYTES & (NUM_DIP_BYTES - 1)) != 0) begin : g_bad_dip
    $error("arcade_input_cfg: NUM_DIP_BYTES must be a power of two in 2..32");
  end
  if (NUM_PORTS < 5) begin : g_bad_ports
    $error("arcade_input_cfg: NUM_PORTS must be at least 5");
  end
  if (CLK3K_HALF < 1) begin : g_bad_half
    $error("arcade_input_cfg: CLK3K_HALF must be at least 1");
  end

  // Configuration state is power-on initialised only: reset is held while
  // the ROM streams in and must not wipe the settings that came with it.
  logic [NUM_DIP_BYTES*8-1:0] shadow_q = '0;
  logic [NUM_DIP_BYTES*8-1:0] sw_q = '0;
  logic                       cfg_valid_q = 1'b0;
  logic [7:0]                 mod_q = 8'd0;
  logic [7:0]                 mod_cur_q = 8'd0;
  logic [NUM_MODS-1:0]        mod_onehot_q = NUM_MODS'(1);
  logic                       dl_q = 1'b0;
  logic [7:0]                 last_idx_q = 8'd0;

  logic [NUM_DIP_BYTES*8-1:0] shadow_d, sw_d;
  logic                       cfg_valid_d, dl_d, commit;
  logic [7:0]                 mod_d, mod_cur_d, last_idx_d;
  logic [NUM_MODS-1:0]        mod_onehot_d;

  always_comb begin
    shadow_d = shadow_q;
    if (ioctl_wr && ioctl_index == 8'(DIP_INDEX) && ioctl_addr[24:AW] == '0) begin
      shadow_d[{ioctl_addr[AW-1:0], 3'b000} +: 8] = ioctl_dout;
    end
    dl_d       = ioctl_download;
    last_idx_d = ioctl_download ? ioctl_index : last_idx_q;
    // Copy from shadow_d so a byte landing on the falling edge is included
    commit      = dl_q && !ioctl_download && (last_idx_q == 8'(DIP_INDEX));
    sw_d        = commit ? shadow_d : sw_q;
    cfg_valid_d = cfg_valid_q | commit;
    mod_d       = (ioctl_wr && ioctl_index == 8'(MOD_INDEX)) ? ioctl_dout : mod_q;
    mod_cur_d   = mod_q;
    mod_onehot_d = '0;
    for (int i = 0; i < NUM_MODS; i++) begin
      mod_onehot_d[i] = (mod_q == 8'(i));
    end
  end

  always_ff @(posedge clk_12) begin
    shadow_q     <= shadow_d;
    sw_q         <= sw_d;
    cfg_valid_q  <= cfg_valid_d;
    mod_q        <= mod_d;
    mod_cur_q    <= mod_cur_d;
    mod_onehot_q <= mod_onehot_d;
    dl_q         <= dl_d;
    last_idx_q   <= last_idx_d;
  end

  assign sw_out     = sw_q;
  assign cfg_valid  = cfg_valid_q;
  assign mod_onehot = mod_onehot_q;

  logic [7:0] sw2;
  if (NUM_DIP_BYTES > 2) begin : g_sw2
    assign sw2 = sw_q[23:16];
  end else begin : g_no_sw2
    assign sw2 = 8'h00;
  end

`ifdef ARCADE_CLK3K_EN
  localparam int DW = (CLK3K_HALF > 1) ? $clog2(CLK3K_HALF) : 1;
  logic [DW-1:0] div_q, div_d;
  logic          clk3k_q, clk3k_d;

  always_comb begin
    div_d   = div_q + 1'b1;
    clk3k_d = clk3k_q;
    if (div_q == DW'(CLK3K_HALF - 1)) begin
      div_d   = '0;
      clk3k_d = ~clk3k_q;
    end
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      div_q   <= '0;
      clk3k_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      clk3k_q <= clk3k_d;
    end
  end

  assign clk3k = clk3k_q;
`else
  assign clk3k = 1'b0;
`endif

  pad_t pad;
  logic coin_s;
  logic unused_joy_bits;

  always_comb begin
    pad            = '0;
    pad.up         = joy_0[JOY_UP];
    pad.down       = joy_0[JOY_DOWN];
    pad.left       = joy_0[JOY_LEFT];
    pad.right      = joy_0[JOY_RIGHT];
    pad.fire_up    = joy_0[JOY_FIRE_UP]    | joy_1[JOY_UP];
    pad.fire_down  = joy_0[JOY_FIRE_DOWN]  | joy_1[JOY_DOWN];
    pad.fire_left  = joy_0[JOY_FIRE_LEFT]  | joy_1[JOY_LEFT];
    pad.fire_right = joy_0[JOY_FIRE_RIGHT] | joy_1[JOY_RIGHT];
    pad.start1     = joy_0[JOY_START1] | joy_1[JOY_START1];
    pad.start2     = joy_0[JOY_START2] | joy_1[JOY_START2];
    pad.coin       = joy_0[JOY_COIN]   | joy_1[JOY_COIN];
  end

  assign unused_joy_bits = &{1'b0, joy_0[15:11], joy_1[15:11], joy_1[7:4]};

  coin_stretch #(
    .HOLD (COIN_HOLD)
  ) u_coin_stretch (
    .clk_12 (clk_12),
    .reset  (reset),
    .coin   (pad.coin),
    .coin_s (coin_s)
  );

  logic [NUM_PORTS*8-1:0] ports_q, ports_d;
  logic [7:0]             sys_byte;

  always_comb begin
    ports_d  = {NUM_PORTS{PORT_IDLE}};
    sys_byte = ~{clk3k, 1'b1, sw2[0], sw2[1], 2'b00, coin_s, 1'b0};
    ports_d[PORT_SW0*8 +: 8] = sw_q[7:0];
    ports_d[PORT_SW1*8 +: 8] = sw_q[15:8];
    if (mod_cur_q < 8'(NUM_MODS)) begin
      case (mod_cur_q)
        MOD_BWIDOW: begin
          ports_d[PORT_SYS*8 +: 8] = sys_byte;
          ports_d[PORT_JOY*8 +: 8] = ~{4'b0000, pad.up, pad.down, pad.left, pad.right};
          ports_d[PORT_BTN*8 +: 8] = ~{1'b0, pad.start2, pad.start1, 1'b0,
                                       pad.fire_up, pad.fire_down, pad.fire_left, pad.fire_right};
        end
        MOD_GRAVITAR: begin
          ports_d[PORT_SYS*8 +: 8] = sys_byte;
          ports_d[PORT_JOY*8 +: 8] = ~{3'b000, pad.fire_left, pad.left, pad.right,
                                       pad.fire_right, pad.fire_down};
          ports_d[PORT_BTN*8 +: 8] = ~{1'b0, pad.start2, pad.start1, 5'b00000};
        end
        MOD_LUNARBAT: begin
          // Lunar Battle reads its control port active-high
          ports_d[PORT_SYS*8 +: 8] = sys_byte;
          ports_d[PORT_SW0*8 +: 8] = PORT_IDLE;
          ports_d[PORT_SW1*8 +: 8] = PORT_IDLE;
          ports_d[PORT_JOY*8 +: 8] = {1'b0, pad.start2, pad.start1, pad.fire_left,
                                      pad.fire_down, pad.fire_right, pad.right, pad.left};
        end
        MOD_SPACDUEL: begin
          ports_d[PORT_SW0*8 +: 8] = PORT_IDLE;
          ports_d[PORT_SW1*8 +: 8] = PORT_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      ports_q <= {NUM_PORTS{PORT_IDLE}};
    end else begin
      ports_q <= ports_d;
    end
  end

  assign input_flat = ports_q;

endmodule

`default_nettype wire

// File: tb/tb_arcade_input_cfg.sv
// ============================================================================
// Module   : tb_arcade_input_cfg
// Brief    : Self-checking bench for arcade_input_cfg (table + random + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_arcade_input_cfg;

  localparam int NDB  = 8;
  localparam int NP   = 6;
  localparam int NM   = 4;
  localparam int DIPI = 254;
  localparam int MODI = 1;
  localparam int HOLD = 100;
  localparam int HALF = 4;

  logic            clk_12 = 1'b0;
  logic            reset = 1'b1;
  logic            ioctl_download = 1'b0;
  logic            ioctl_wr = 1'b0;
  logic [24:0]     ioctl_addr = '0;
  logic [7:0]      ioctl_dout = '0;
  logic [7:0]      ioctl_index = '0;
  logic [15:0]     joy_0 = '0;
  logic [15:0]     joy_1 = '0;
  logic [NDB*8-1:0] sw_out;
  logic [NM-1:0]   mod_onehot;
  logic            cfg_valid;
  logic [NP*8-1:0] input_flat;
  logic            clk3k;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sw_m [NDB];
  logic [7:0] mod_m = 8'd0;

  always #5 clk_12 = ~clk_12;

  arcade_input_cfg #(
    .NUM_DIP_BYTES (NDB),
    .NUM_PORTS     (NP),
    .NUM_MODS      (NM),
    .DIP_INDEX     (DIPI),
    .MOD_INDEX     (MODI),
    .COIN_HOLD     (HOLD),
    .CLK3K_HALF    (HALF)
  ) dut (
    .clk_12         (clk_12),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .joy_0          (joy_0),
    .joy_1          (joy_1),
    .sw_out         (sw_out),
    .mod_onehot     (mod_onehot),
    .cfg_valid      (cfg_valid),
    .input_flat     (input_flat),
    .clk3k          (clk3k)
  );

  typedef struct {
    logic [7:0]  mod;
    logic [15:0] j0;
    logic [15:0] j1;
    logic [7:0]  p0, p1, p2, p3, p4;
  } vec_t;

  vec_t tbl [10];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_12);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sw_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NDB; k++) v[k*8 +: 8] = sw_m[k];
    return v;
  endfunction

  // Reference port image built directly from the game mapping rules
  function automatic logic [NP*8-1:0] model_ports(input logic [7:0] mod, input logic [15:0] j0,
                                                   input logic [15:0] j1, input logic coin_s,
                                                   input logic k3);
    logic [NP*8-1:0] r;
    logic [15:0] j;
    logic up, dn, lf, rt, fu, fd, fl, fr, s1, s2;
    logic [7:0] sys;
    j  = j0 | j1;
    up = j0[3]; dn = j0[2]; lf = j0[1]; rt = j0[0];
    fu = j0[6] | j1[3]; fd = j0[7] | j1[2]; fl = j0[5] | j1[1]; fr = j0[4] | j1[0];
    s1 = j[8]; s2 = j[9];
    sys = ~{k3, 1'b1, sw_m[2][0], sw_m[2][1], 2'b00, coin_s, 1'b0};
    r = {NP{8'hff}};
    r[15:8]  = sw_m[0];
    r[23:16] = sw_m[1];
    if (mod == 8'd0) begin
      r[7:0] = sys;
      r[31:24] = ~{4'b0000, up, dn, lf, rt};
      r[39:32] = ~{1'b0, s2, s1, 1'b0, fu, fd, fl, fr};
    end else if (mod == 8'd1) begin
      r[7:0] = sys;
      r[31:24] = ~{3'b000, fl, lf, rt, fr, fd};
      r[39:32] = ~{1'b0, s2, s1, 5'b00000};
    end else if (mod == 8'd2) begin
      r[7:0] = sys;
      r[15:8] = 8'hff;
      r[23:16] = 8'hff;
      r[31:24] = {1'b0, s2, s1, fl, fd, fr, rt, lf};
    end else if (mod == 8'd3) begin
      r[15:8] = 8'hff;
      r[23:16] = 8'hff;
    end
    return r;
  endfunction

  function automatic logic [NP*8-1:0] k3_mask();
    logic [NP*8-1:0] m;
    m = '1;
`ifdef ARCADE_CLK3K_EN
    m[7] = 1'b0;
`endif
    return m;
  endfunction

  task automatic set_mod(input logic [7:0] v);
    ioctl_index = 8'(MODI);
    ioctl_dout  = v;
    ioctl_wr    = 1'b1;
    cyc(1);
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    mod_m       = v;
  endtask

  task automatic coin_run(input string name, input int on0, input int gap, input int on1,
                          input int exp_low, input bit use_j1);
    int low_cnt;
    int first_low;
    logic cv;
    low_cnt   = 0;
    first_low = -1;
    for (int c = 0; c < 300; c++) begin
      cv = (c < on0) || (c >= on0 + gap && c < on0 + gap + on1);
      if (use_j1) joy_1[10] = cv; else joy_0[10] = cv;
      cyc(1);
      if (input_flat[1] == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
    end
    check({name, "_width"}, 64'(low_cnt), 64'(exp_low));
    check({name, "_latency"}, 64'(first_low), 64'd1);
  endtask

  initial begin
    logic [NP*8-1:0] exp_v;
    for (int k = 0; k < NDB; k++) sw_m[k] = 8'h00;

    tbl[0] = '{8'd0, 16'h0009, 16'h0000, 8'h8f, 8'h11, 8'h22, 8'hf6, 8'hff};
    tbl[1] = '{8'd0, 16'h0350, 16'h0000, 8'h8f, 8'h11, 8'h22, 8'hff, 8'h96};
    tbl[2] = '{8'd0, 16'h0000, 16'h0306, 8'h8f, 8'h11, 8'h22, 8'hff, 8'h99};
    tbl[3] = '{8'd1, 16'h00a2, 16'h0000, 8'h8f, 8'h11, 8'h22, 8'he6, 8'hff};
    tbl[4] = '{8'd1, 16'h0201, 16'h0001, 8'h8f, 8'h11, 8'h22, 8'hf9, 8'hbf};
    tbl[5] = '{8'd2, 16'h0000, 16'h0001, 8'h8f, 8'hff, 8'hff, 8'h04, 8'hff};
    tbl[6] = '{8'd2, 16'h01a3, 16'h0000, 8'h8f, 8'hff, 8'hff, 8'h3b, 8'hff};
    tbl[7] = '{8'd3, 16'h03ff, 16'h0000, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
    tbl[8] = '{8'd7, 16'h0009, 16'h0000, 8'hff, 8'h11, 8'h22, 8'hff, 8'hff};
    tbl[9] = '{8'd4, 16'h0350, 16'h0000, 8'hff, 8'h11, 8'h22, 8'hff, 8'hff};

    // Reset state
    cyc(3);
    check("reset_ports", 64'(input_flat), 64'({NP{8'hff}}));
    check("reset_sw", sw_out, 64'd0);
    check("reset_cfg_valid", 64'(cfg_valid), 64'd0);
    check("reset_mod_onehot", 64'(mod_onehot), 64'd1);
    check("reset_clk3k", 64'(clk3k), 64'd0);
    reset = 1'b0;

    // Full DIP download
    ioctl_download = 1'b1;
    ioctl_index    = 8'(DIPI);
    for (int i = 0; i < NDB; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(17 * (i + 1));
      cyc(1);
      if (i == 3) check("sw_mid_stream", sw_out, 64'd0);
    end
    ioctl_wr = 1'b0;
    cyc(1);
    check("sw_before_commit", sw_out, 64'd0);
    ioctl_download = 1'b0;
    cyc(1);
    for (int k = 0; k < NDB; k++) sw_m[k] = 8'(17 * (k + 1));
    check("sw_commit", sw_out, 64'h8877665544332211);
    check("cfg_valid_set", 64'(cfg_valid), 64'd1);

    // Out-of-range writes dropped; write on the falling edge is included
    ioctl_download = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd8;
    ioctl_dout = 8'hee;
    cyc(1);
    ioctl_addr = 25'h100;
    cyc(1);
    ioctl_download = 1'b0;
    ioctl_addr = 25'd3;
    ioctl_dout = 8'ha5;
    cyc(1);
    ioctl_wr = 1'b0;
    sw_m[3] = 8'ha5;
    check("sw_edge_write", sw_out, 64'h88776655a5332211);

    // A download whose last index is not the DIP index must not commit
    ioctl_download = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'h5a;
    cyc(1);
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    cyc(1);
    ioctl_download = 1'b0;
    cyc(2);
    check("sw_no_commit_other_index", sw_out, sw_vec());

    // Reset keeps configuration
    set_mod(8'd1);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("reset_pulse_ports", 64'(input_flat), 64'({NP{8'hff}}));
    check("reset_keeps_sw", sw_out, sw_vec());
    check("reset_keeps_mod", 64'(mod_onehot), 64'd2);
    check("reset_keeps_cfg_valid", 64'(cfg_valid), 64'd1);
    reset = 1'b0;

    // Table-driven mapping
    for (int t = 0; t < 10; t++) begin
      joy_0 = tbl[t].j0;
      joy_1 = tbl[t].j1;
      set_mod(tbl[t].mod);
      cyc(1);
      check($sformatf("tbl%0d_onehot", t), 64'(mod_onehot),
            (tbl[t].mod < 8'(NM)) ? (64'd1 << tbl[t].mod) : 64'd0);
      cyc(1);
      exp_v = {8'hff, tbl[t].p4, tbl[t].p3, tbl[t].p2, tbl[t].p1, tbl[t].p0};
      check($sformatf("tbl%0d_ports", t), 64'(input_flat & k3_mask()), 64'(exp_v & k3_mask()));
    end

    // Randomised joysticks and game selects against the model
    for (int it = 0; it < 150; it++) begin
      if (it % 25 == 0) begin
        set_mod(8'($urandom_range(0, 7)));
        cyc(1);
      end
      joy_0 = 16'($urandom) & 16'hfbff;
      joy_1 = 16'($urandom) & 16'hfbff;
      cyc(1);
      exp_v = model_ports(mod_m, joy_0, joy_1, 1'b0, 1'b0);
      check($sformatf("rand%0d_mod%0d", it, mod_m), 64'(input_flat & k3_mask()),
            64'(exp_v & k3_mask()));
    end

    // Coin stretcher
    joy_0 = '0;
    joy_1 = '0;
    set_mod(8'd0);
    cyc(3);
    coin_run("coin_short", 3, 0, 0, HOLD, 1'b0);
    coin_run("coin_long", 150, 0, 0, 150, 1'b1);
    coin_run("coin_retrigger", 3, 10, 3, HOLD, 1'b0);

    joy_0[10] = 1'b1;
    cyc(1);
    joy_0[10] = 1'b0;
    cyc(20);
    check("coin_hold_active", 64'(input_flat[1]), 64'd0);
    reset = 1'b1;
    cyc(1);
    check("coin_reset_ports", 64'(input_flat), 64'({NP{8'hff}}));
    reset = 1'b0;
    cyc(1);
    check("coin_reset_abort", 64'(input_flat[1]), 64'd1);
    cyc(5);
    check("coin_reset_stays_idle", 64'(input_flat[1]), 64'd1);

    // clk3k divider and port 0 bit 7
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      cyc(1);
`ifdef ARCADE_CLK3K_EN
      check($sformatf("clk3k_n%0d", n), 64'(clk3k), 64'((n / HALF) % 2));
      check($sformatf("p0b7_n%0d", n), 64'(input_flat[7]), 64'(1 - (((n - 1) / HALF) % 2)));
`else
      check($sformatf("clk3k_n%0d", n), 64'(clk3k), 64'd0);
      check($sformatf("p0b7_n%0d", n), 64'(input_flat[7]), 64'd1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
